bch_detect_arbiter: RTL and testbench

- Shares one BCH(542,512) syndrome/detection datapath (bch_detector, 5 x 10-bit syndromes) between two requesters: the host read path and the patrol-scrub engine.
- Arbitrates with read priority and a scrub starvation guard, then registers the codeword, syndromes and detect flag into a single-entry output stage with a valid/ready handshake.
- Keeps a saturating count of codewords flagged as erroneous.
- Sits between the on-die array read mux and the downstream BCH decoder/corrector.

---
 rtl/bch_detect_arbiter.sv | 118 +++++++++++
 tb/tb_bch_detect_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bch_detect_arbiter.sv
// bch_detect_arbiter: read/scrub arbiter sharing one BCH(542,512) detector with a registered output stage.
// Optional BCH_DET_DROP_CLEAN_SCRUB_EN: clean scrub words are consumed without producing a result.
module bch_detector #(
    parameter int N     = 542,
    parameter int SYN_W = 10
) (
    input  logic [N-1:0]       data,
    output logic [5*SYN_W-1:0] syn,
    output logic               detect
);
    localparam logic [SYN_W-1:0] POLY = SYN_W'(9);
    // Horner evaluation of r(alpha^j) in GF(2^10), x^10 + x^3 + 1, MSB coefficient first
    function automatic logic [SYN_W-1:0] syndrome(input logic [N-1:0] r, input int p);
        logic [SYN_W-1:0] s;
        s = '0;
        for (int i = N - 1; i >= 0; i--) begin
            for (int k = 0; k < p; k++) s = {s[SYN_W-2:0], 1'b0} ^ (s[SYN_W-1] ? POLY : '0);
            s[0] = s[0] ^ r[i];
        end
        return s;
    endfunction
    for (genvar j = 0; j < 5; j++) begin : g_syn
        assign syn[j*SYN_W +: SYN_W] = syndrome(data, j + 1);
    end
    assign detect = |syn;
endmodule

module bch_detect_arbiter #(
    parameter int N              = 542,
    parameter int SYN_W          = 10,
    parameter int TAG_W          = 4,
    parameter int CNT_W          = 16,
    parameter int SCRUB_MAX_WAIT = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rd_valid,
    output logic               rd_ready,
    input  logic [N-1:0]       rd_data,
    input  logic [TAG_W-1:0]   rd_tag,
    input  logic               sc_valid,
    output logic               sc_ready,
    input  logic [N-1:0]       sc_data,
    input  logic [TAG_W-1:0]   sc_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_src,
    output logic [TAG_W-1:0]   out_tag,
    output logic [N-1:0]       out_data,
    output logic [5*SYN_W-1:0] out_syn,
    output logic               out_detect,
    output logic [CNT_W-1:0]   err_count,
    input  logic               err_count_clr
);
    localparam int SW = $clog2(SCRUB_MAX_WAIT + 1);
    localparam logic [SW-1:0] MAXW = SW'(SCRUB_MAX_WAIT);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state, state_nx;
    logic [SW-1:0] starve_cnt, starve_nx;
    logic [CNT_W-1:0] err_nx;
    logic can_load, sc_win, gnt_rd, gnt_sc, load, det;
    logic [N-1:0] mux_data;
    logic [5*SYN_W-1:0] syn;

    // readys are held low during reset so nothing is consumed while the stage is cleared
    assign out_valid = (state == FULL);
    assign can_load  = rst_n && (!out_valid || out_ready);
    assign sc_win    = sc_valid && (!rd_valid || starve_cnt == MAXW);
    assign gnt_sc    = can_load && sc_win;
    assign gnt_rd    = can_load && rd_valid && !sc_win;
    assign rd_ready  = gnt_rd;
    assign sc_ready  = gnt_sc;
    assign mux_data  = gnt_sc ? sc_data : rd_data;

    bch_detector #(.N(N), .SYN_W(SYN_W)) u_det (
        .data   (mux_data),
        .syn    (syn),
        .detect (det)
    );

`ifdef BCH_DET_DROP_CLEAN_SCRUB_EN
    assign load = gnt_rd || (gnt_sc && det);
`else
    assign load = gnt_rd || gnt_sc;
`endif

    always_comb begin
        state_nx  = load ? FULL : (out_ready ? EMPTY : state);
        starve_nx = (gnt_rd && sc_valid) ? ((starve_cnt == MAXW) ? starve_cnt : starve_cnt + 1'b1)
                  : (gnt_rd || gnt_sc) ? '0 : starve_cnt;
        err_nx    = err_count_clr ? '0
                  : (load && det && !(&err_count)) ? err_count + 1'b1 : err_count;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= EMPTY;
            starve_cnt <= '0;
            out_src    <= 1'b0;
            out_tag    <= '0;
            out_data   <= '0;
            out_syn    <= '0;
            out_detect <= 1'b0;
            err_count  <= '0;
        end else begin
            state      <= state_nx;
            starve_cnt <= starve_nx;
            err_count  <= err_nx;
            if (load) begin
                out_src    <= gnt_sc;
                out_tag    <= gnt_sc ? sc_tag : rd_tag;
                out_data   <= mux_data;
                out_syn    <= syn;
                out_detect <= det;
            end
        end
    end
endmodule

// File: tb/tb_bch_detect_arbiter.sv
// tb_bch_detect_arbiter: scoreboard bench; a transaction model predicts grants and results, the monitor compares.
module tb_bch_detect_arbiter;
    localparam int W = 542;
    localparam int MAXW = 8;

    logic clk, rst_n;
    logic rd_valid, rd_ready, sc_valid, sc_ready;
    logic [W-1:0] rd_data, sc_data, out_data;
    logic [3:0] rd_tag, sc_tag, out_tag;
    logic out_valid, out_ready, out_src, out_detect, err_count_clr;
    logic [49:0] out_syn;
    logic [15:0] err_count;

    bch_detect_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_tag(rd_tag),
        .sc_valid(sc_valid), .sc_ready(sc_ready), .sc_data(sc_data), .sc_tag(sc_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src), .out_tag(out_tag),
        .out_data(out_data), .out_syn(out_syn), .out_detect(out_detect),
        .err_count(err_count), .err_count_clr(err_count_clr)
    );

    typedef struct {
        logic         src;
        logic [3:0]   tag;
        logic [W-1:0] data;
        logic [49:0]  syn;
        logic         det;
    } res_t;

    res_t q[$];
    res_t e;
    int n_checks = 0;
    int n_fail = 0;
    logic [9:0] alpha[1023];
    logic m_valid = 0;
    int m_starve = 0;
    logic [15:0] m_err = 0;
    logic can, sc_win, exp_rd, exp_sc, ld;
    logic [W-1:0] d;

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        logic [10:0] a;
        a = 11'd1;
        for (int k = 0; k < 1023; k++) begin
            alpha[k] = a[9:0];
            a = a << 1;
            if (a[10]) a = a ^ 11'h409;
        end
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // S_j = XOR of alpha^(i*j) over set bits i, from an antilog table
    function automatic logic [49:0] model_syn(input logic [W-1:0] x);
        logic [49:0] s;
        s = '0;
        for (int j = 1; j <= 5; j++)
            for (int i = 0; i < W; i++)
                if (x[i]) s[(j-1)*10 +: 10] = s[(j-1)*10 +: 10] ^ alpha[(i * j) % 1023];
        return s;
    endfunction

    function automatic logic [W-1:0] rand_word(input int mode);
        logic [W-1:0] x;
        x = '0;
        if (mode == 1) x[$urandom_range(W - 1)] = 1'b1;
        if (mode == 2) begin
            x[$urandom_range(W - 1)] = 1'b1;
            x[$urandom_range(W - 1)] = 1'b1;
        end
        if (mode == 3) for (int i = 0; i < W; i++) x[i] = 1'($urandom);
        return x;
    endfunction

    // monitor: compare the held result against the scoreboard, then predict the coming edge
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("out_valid", W'(out_valid), W'(m_valid));
            check("err_count", W'(err_count), W'(m_err));
            if (m_valid) begin
                e = q[0];
                check("out_src", W'(out_src), W'(e.src));
                check("out_tag", W'(out_tag), W'(e.tag));
                check("out_data", out_data, e.data);
                check("out_syn", W'(out_syn), W'(e.syn));
                check("out_detect", W'(out_detect), W'(e.det));
            end
            can = rst_n && (!m_valid || out_ready);
            sc_win = sc_valid && (!rd_valid || m_starve == MAXW);
            exp_sc = can && sc_win;
            exp_rd = can && rd_valid && !sc_win;
            check("rd_ready", W'(rd_ready), W'(exp_rd));
            check("sc_ready", W'(sc_ready), W'(exp_sc));
            if (!rst_n) begin
                q.delete();
                m_valid = 0;
                m_starve = 0;
                m_err = 0;
            end else begin
                d = exp_sc ? sc_data : rd_data;
                e.src = exp_sc;
                e.tag = exp_sc ? sc_tag : rd_tag;
                e.data = d;
                e.syn = model_syn(d);
                e.det = |e.syn;
`ifdef BCH_DET_DROP_CLEAN_SCRUB_EN
                ld = exp_rd || (exp_sc && e.det);
`else
                ld = exp_rd || exp_sc;
`endif
                if (m_valid && out_ready) void'(q.pop_front());
                if (ld) q.push_back(e);
                if (err_count_clr) m_err = 0;
                else if (ld && e.det && m_err != 16'hFFFF) m_err = m_err + 1;
                if (exp_rd && sc_valid) m_starve = (m_starve == MAXW) ? MAXW : m_starve + 1;
                else if (exp_rd || exp_sc) m_starve = 0;
                m_valid = ld ? 1'b1 : (out_ready ? 1'b0 : m_valid);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] err7;
        err7 = '0;
        err7[7] = 1'b1;
        rst_n = 0; rd_valid = 1; rd_data = '0; rd_tag = 4'h1;
        sc_valid = 0; sc_data = '0; sc_tag = 4'h0;
        out_ready = 1; err_count_clr = 0;
        tick(2);
        rst_n = 1;
        tick();
        rd_valid = 0;
        check("first_load", W'({out_valid, out_detect, out_syn}), W'({1'b1, 1'b0, 50'h0}));
        tick();
        rd_data = err7; rd_tag = 4'h3; rd_valid = 1;
        tick();
        rd_valid = 0;
        check("bit7_detect", W'({out_detect, out_src, out_tag}), W'({1'b1, 1'b0, 4'h3}));
        check("bit7_err_count", W'(err_count), W'(1));
        tick();
        for (int c = 0; c < 60; c++) begin
            rd_valid = 1'($urandom); sc_valid = 1'($urandom);
            rd_data = rand_word($urandom_range(3)); sc_data = rand_word($urandom_range(3));
            rd_tag = 4'($urandom); sc_tag = 4'($urandom);
            out_ready = ($urandom_range(3) != 0);
            tick();
        end
        out_ready = 1; rd_valid = 0; sc_valid = 0;
        tick(2);
        rd_valid = 1; sc_valid = 1; rd_data = err7; sc_data = rand_word(1);
        rd_tag = 4'h6; sc_tag = 4'h9;
        tick(27);
        out_ready = 0;
        tick(5);
        out_ready = 1;
        tick(6);
        out_ready = 0;
        tick(2);
        rst_n = 0;
        tick();
        rst_n = 1;
        check("mid_reset", W'(out_valid), W'(0));
        out_ready = 1; sc_valid = 0; rd_data = err7;
        tick(65540);
        check("err_sat", W'(err_count), W'(16'hFFFF));
        tick();
        check("err_sat_hold", W'(err_count), W'(16'hFFFF));
        err_count_clr = 1;
        tick();
        err_count_clr = 0; rd_valid = 0;
        check("err_clr", W'(err_count), W'(0));
        tick(2);
        sc_valid = 1; sc_data = '0; sc_tag = 4'h5;
        tick();
`ifdef BCH_DET_DROP_CLEAN_SCRUB_EN
        check("clean_scrub_dropped", W'(out_valid), W'(0));
`else
        check("clean_scrub_kept", W'({out_valid, out_src}), W'({1'b1, 1'b1}));
`endif
        sc_data = err7;
        tick();
        sc_valid = 0;
        check("err_scrub", W'({out_valid, out_src, out_detect}), W'({1'b1, 1'b1, 1'b1}));
        tick(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
